// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video output generator and the video input reader:
// default raster geometry, counter width and the run/idle state encoding.
// -----------------------------------------------------------------------------
package video_pkg;

  // Default raster: 640x480 active, 160 blanking cycles per line and
  // 40 blanking lines per frame (800 x 520 total).
  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;
  localparam int LSYNC_DEF  = 160;
  localparam int FSYNC_DEF  = 40;

  // Raster position counters are 10 bits wide (covers 0..799 and 0..519).
  localparam int CNT_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } video_state_e;

endpackage

// File: rtl/video_out_timing.sv
// -----------------------------------------------------------------------------
// video_out_timing
// Run/idle controller and raster position counters for the video output path.
//
// Ports:
//   clk        - clock, rising edge
//   nRST       - asynchronous active-low reset
//   en         - frame generation enable
//   fifo_empty - pixel FIFO empty flag (a frame only starts with data ready)
//   run        - high while a frame is being generated
//   h_cnt      - pixel position in the line, 0..p_WIDTH+p_LSYNC-1
//   v_cnt      - line position in the frame, 0..p_HEIGHT+p_FSYNC-1
// -----------------------------------------------------------------------------
module video_out_timing
  import video_pkg::*;
#(
  parameter int p_WIDTH  = WIDTH_DEF,
  parameter int p_HEIGHT = HEIGHT_DEF,
  parameter int p_LSYNC  = LSYNC_DEF,
  parameter int p_FSYNC  = FSYNC_DEF
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(p_WIDTH + p_LSYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(p_HEIGHT + p_FSYNC - 1);

  video_state_e state;
  video_state_e next_state;
  logic         line_end;
  logic         frame_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign run       = (state == ST_RUN);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state <= next_state;
    end
  end

  // en is only consulted on the final cycle of a frame, so dropping it
  // mid-frame lets the current frame finish.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    case (state)
      ST_IDLE: if (en && !fifo_empty) next_state = ST_RUN;
      ST_RUN:  if (frame_end && !en)  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state != ST_RUN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_out_gen.sv
// -----------------------------------------------------------------------------
// video_out_gen
// Streams 32-bit words from a show-ahead FIFO out as a raster of 8-bit pixels,
// four pixels per word (most significant byte first), with line/frame valid
// strobes and a sticky underflow flag.
//
// Ports:
//   clk         - clock, rising edge
//   nRST        - asynchronous active-low reset
//   en          - frame generation enable
//   fifo_data   - FIFO head word, valid while fifo_empty is low
//   fifo_empty  - FIFO empty flag
//   fifo_r_e    - FIFO pop (combinational), one word per asserted cycle
//   pixel_out   - registered pixel byte, zero outside active pixels
//   line_valid  - registered, high on active pixels
//   frame_valid - registered, high during active lines incl. their blanking
//   underflow   - registered, sticky until reset: a group start found no data
// -----------------------------------------------------------------------------
module video_out_gen
  import video_pkg::*;
#(
  parameter int p_WIDTH  = WIDTH_DEF,
  parameter int p_HEIGHT = HEIGHT_DEF,
  parameter int p_LSYNC  = LSYNC_DEF,
  parameter int p_FSYNC  = FSYNC_DEF
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        en,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_r_e,
  output logic [7:0]  pixel_out,
  output logic        line_valid,
  output logic        frame_valid,
  output logic        underflow
);

  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(p_WIDTH);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(p_HEIGHT);

  logic             run;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             in_frame;
  logic             active;
  logic             group_start;
  logic [23:0]      stored;

  video_out_timing #(
    .p_WIDTH  (p_WIDTH),
    .p_HEIGHT (p_HEIGHT),
    .p_LSYNC  (p_LSYNC),
    .p_FSYNC  (p_FSYNC)
  ) u_timing (
    .clk        (clk),
    .nRST       (nRST),
    .en         (en),
    .fifo_empty (fifo_empty),
    .run        (run),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt)
  );

  assign in_frame    = run && (v_cnt < V_ACT);
  assign active      = in_frame && (h_cnt < H_ACT);
  assign group_start = active && (h_cnt[1:0] == 2'd0);
  // Run state is cleared asynchronously by nRST, so no pop can leak out
  // while reset is held.
  assign fifo_r_e    = group_start && !fifo_empty;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the stored word is reset too so a reset mid-group can never
      // replay stale bytes from an abandoned frame.
      pixel_out   <= '0;
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      underflow   <= 1'b0;
      stored      <= '0;
    end else begin
      line_valid  <= active;
      frame_valid <= in_frame;
      if (group_start) begin
        if (!fifo_empty) begin
          pixel_out <= fifo_data[31:24];
          stored    <= fifo_data[23:0];
        end else begin
          // Starved group: emit four zero pixels, raster timing untouched.
          pixel_out <= '0;
          stored    <= '0;
          underflow <= 1'b1;
        end
      end else if (active) begin
        case (h_cnt[1:0])
          2'd1:    pixel_out <= stored[23:16];
          2'd2:    pixel_out <= stored[15:8];
          default: pixel_out <= stored[7:0];
        endcase
      end else begin
        pixel_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_video_out_gen.sv
// -----------------------------------------------------------------------------
// tb_video_out_gen
// Self-checking bench for video_out_gen on a reduced raster. A behavioural
// model tracks the frame as a single cycle index (position = index / line
// length, index % line length) and a queue stands in for the FIFO.
// -----------------------------------------------------------------------------
module tb_video_out_gen;

  localparam int W     = 16;
  localparam int H     = 6;
  localparam int LS    = 8;
  localparam int FS    = 3;
  localparam int LINE  = W + LS;
  localparam int FRAME = LINE * (H + FS);

  logic        clk;
  logic        nRST;
  logic        en;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_r_e;
  logic [7:0]  pixel_out;
  logic        line_valid;
  logic        frame_valid;
  logic        underflow;

  video_out_gen #(
    .p_WIDTH  (W),
    .p_HEIGHT (H),
    .p_LSYNC  (LS),
    .p_FSYNC  (FS)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .en          (en),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_r_e    (fifo_r_e),
    .pixel_out   (pixel_out),
    .line_valid  (line_valid),
    .frame_valid (frame_valid),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO stand-in and stimulus knobs
  logic [31:0] q[$];
  int          refill_mode = 0;  // 0 none, 1 constant 0x01020304, 2 random
  int          push_pct    = 0;

  // Reference model
  bit          m_run;
  int          m_idx;
  logic [31:0] m_word;
  logic [7:0]  e_pix;
  bit          e_lv, e_fv, e_uf;

  // Observation bookkeeping
  int cyc = 0;
  int en_cyc;
  bit lat_armed = 0;
  bit cnt_on = 0;
  int lv_count, zero_count;
  bit stats_on = 0;
  bit lv_prev, fv_prev, gap_ok, frame_armed;
  int hi_run, low_run, pop_line, lv_frame, fv_hi, fv_lo, pop_frame;

  task automatic model_reset();
    m_run  = 0;
    m_idx  = 0;
    m_word = '0;
    e_pix  = '0;
    e_lv   = 0;
    e_fv   = 0;
    e_uf   = 0;
  endtask

  function automatic bit exp_pop();
    int h = m_idx % LINE;
    int v = m_idx / LINE;
    return m_run && h < W && v < H && (h % 4) == 0 && q.size() > 0;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle.
  task automatic model_edge();
    int h, v;
    bit act;
    if (!nRST) begin
      model_reset();
      return;
    end
    h   = m_idx % LINE;
    v   = m_idx / LINE;
    act = m_run && h < W && v < H;
    e_lv = act;
    e_fv = m_run && v < H;
    if (act) begin
      if (h % 4 == 0) begin
        if (q.size() > 0) m_word = q[0];
        else begin
          m_word = '0;
          e_uf   = 1;
        end
      end
      e_pix = 8'((m_word >> (8 * (3 - h % 4))) & 32'hff);
    end else begin
      e_pix = '0;
    end
    if (!m_run) begin
      if (en && q.size() > 0) begin
        m_run = 1;
        m_idx = 0;
      end
    end else if (m_idx == FRAME - 1) begin
      m_idx = 0;
      m_run = en;
    end else begin
      m_idx++;
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : $urandom;
  endtask

  task automatic refill();
    if (refill_mode == 1) begin
      while (q.size() < 8) q.push_back(32'h01020304);
    end else if (refill_mode == 2) begin
      if ($urandom_range(0, 99) < push_pct) q.push_back($urandom);
      if ($urandom_range(0, 39) == 0) en = ~en;
    end
  endtask

  task automatic stats_clear();
    lv_prev = 0; fv_prev = 0; gap_ok = 0; frame_armed = 0;
    hi_run = 0; low_run = 0; pop_line = 0;
    lv_frame = 0; fv_hi = 0; fv_lo = 0; pop_frame = 0;
  endtask

  task automatic do_stats();
    if (line_valid && !lv_prev) begin
      if (gap_ok) begin
        check("lv_low_len", 32'(low_run), 32'(LS));
        check("pops_per_line", 32'(pop_line), 32'(W / 4));
      end
      pop_line = 0;
      hi_run   = 0;
    end
    if (!line_valid && lv_prev) begin
      check("lv_high_len", 32'(hi_run), 32'(W));
      low_run = 0;
      gap_ok  = 1;
    end
    if (frame_valid && !fv_prev) begin
      if (frame_armed) begin
        check("lv_per_frame", 32'(lv_frame), 32'(W * H));
        check("fv_high_len", 32'(fv_hi), 32'(H * LINE));
        check("fv_low_len", 32'(fv_lo), 32'(FS * LINE));
        check("pops_per_frame", 32'(pop_frame), 32'(W * H / 4));
      end
      frame_armed = 1;
      lv_frame = 0; fv_hi = 0; fv_lo = 0; pop_frame = 0;
    end
    if (line_valid) begin
      hi_run++;
      lv_frame++;
    end else begin
      low_run++;
      if (!frame_valid) gap_ok = 0;
    end
    if (frame_valid) fv_hi++; else fv_lo++;
    if (fifo_r_e) begin
      pop_line++;
      pop_frame++;
    end
    lv_prev = line_valid;
    fv_prev = frame_valid;
  endtask

  // One clock: compare at the falling edge, then update model and FIFO just
  // after the rising edge.
  task automatic step();
    bit pop;
    @(negedge clk);
    cyc++;
    check("fifo_r_e", 32'(fifo_r_e), 32'(exp_pop()));
    check("pixel_out", 32'(pixel_out), 32'(e_pix));
    check("line_valid", 32'(line_valid), 32'(e_lv));
    check("frame_valid", 32'(frame_valid), 32'(e_fv));
    check("underflow", 32'(underflow), 32'(e_uf));
    if (stats_on) do_stats();
    if (lat_armed && line_valid) begin
      check("en_to_lv_latency", 32'(cyc - en_cyc - 1), 32'd2);
      check("first_pixel", 32'(pixel_out), 32'h01);
      lat_armed = 0;
    end
    if (cnt_on && line_valid) begin
      lv_count++;
      if (pixel_out == 8'h00) zero_count++;
    end
    pop = fifo_r_e;
    @(posedge clk);
    #1;
    model_edge();
    if (pop && q.size() > 0) q.delete(0);
    refill();
    drive_fifo();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix"}, 32'(pixel_out), 32'h0);
    check({tag, "_lv"}, 32'(line_valid), 32'h0);
    check({tag, "_fv"}, 32'(frame_valid), 32'h0);
    check({tag, "_pop"}, 32'(fifo_r_e), 32'h0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    nRST = 1'b0;
    #1;
    model_reset();
    check_outputs_zero("rst");
    check("rst_uf", 32'(underflow), 32'h0);
    repeat (2) step();
    nRST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b1;
    en   = 1'b0;
    model_reset();
    drive_fifo();
    #2;

    // Full FIFO of 0x01020304: latency, pixel pattern, line/frame timing, pops.
    apply_reset();
    refill_mode = 1;
    refill();
    drive_fifo();
    stats_clear();
    stats_on  = 1;
    en        = 1'b1;
    en_cyc    = cyc;
    lat_armed = 1;
    repeat (3 * FRAME + 20) step();
    stats_on = 0;
    check("lat_seen", 32'(lat_armed), 32'h0);
    check("frames_seen", 32'(frame_armed), 32'h1);

    // Underflow: FIFO holds exactly enough for 2.5 lines.
    apply_reset();
    refill_mode = 0;
    q.delete();
    for (int i = 0; i < 2 * (W / 4) + 2; i++) q.push_back($urandom | 32'h01010101);
    drive_fifo();
    lv_count = 0; zero_count = 0; cnt_on = 1;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (FRAME + 10) step();
    cnt_on = 0;
    check("uf_lv_count", 32'(lv_count), 32'(W * H));
    check("uf_zero_pixels", 32'(zero_count), 32'(W * H - 4 * (2 * (W / 4) + 2)));
    check("uf_sticky", 32'(underflow), 32'h1);
    check_outputs_zero("uf_idle");

    // en dropped at line 4: frame completes, then idle.
    apply_reset();
    refill_mode = 1;
    refill();
    drive_fifo();
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(m_run && m_idx == 4 * LINE); i++) step();
    check("reach_line4", 32'(m_run && m_idx == 4 * LINE), 32'h1);
    en = 1'b0;
    lv_count = 0; cnt_on = 1;
    repeat (2 * FRAME) step();
    cnt_on = 0;
    check("en_low_lv_rest", 32'(lv_count), 32'((H - 4) * W));
    check_outputs_zero("en_low_idle");
    check("en_low_uf", 32'(underflow), 32'h0);

    // Reset pulse at line 1 pixel 5, then restart from the top.
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(m_run && m_idx == LINE + 5); i++) step();
    check("reach_l1p5", 32'(m_run && m_idx == LINE + 5), 32'h1);
    repeat (2) step();
    apply_reset();
    en_cyc    = cyc;
    lat_armed = 1;
    repeat (LINE * 2) step();
    check("restart_seen", 32'(lat_armed), 32'h0);

    // Randomised traffic: random words, bursty refills, random en.
    apply_reset();
    refill_mode = 2;
    q.delete();
    drive_fifo();
    for (int blk = 0; blk < 8; blk++) begin
      push_pct = $urandom_range(0, 30);
      repeat (200) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
